// File: rtl/hilo_div_ctrl_pkg.sv
// hilo_div_ctrl_pkg
// Shared types and constants for the HI/LO divide controller.
// State encodings, default iteration count and the execute-stage opcode
// decode used to drive start/signed_op.

package hilo_div_ctrl_pkg;

  // One quotient bit per CALC cycle, so iterations equal operand width.
  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Execute-stage ALU opcodes for the two divide flavours.
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // True for either divide opcode; execute uses this to raise start.
  function automatic logic is_div_op(input logic [7:0] aluop);
    return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
  endfunction

  // Signed flavour select for signed_op.
  function automatic logic is_signed_div(input logic [7:0] aluop);
    return (aluop == EXE_DIV_OP);
  endfunction

endpackage

// File: rtl/hilo_div_ctrl_div_step.sv
// hilo_div_ctrl_div_step
// One combinational radix-2 restoring iteration: shift {rem,quo} left by
// one, trial-subtract the divisor magnitude, keep the difference and set
// the new quotient LSB when the difference is non-negative.

module hilo_div_ctrl_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH-1:0] rem_low;
  logic             ge;

  // Shifted remainder is WIDTH+1 bits wide; its top bit is rem_in's MSB.
  // When that bit is set the shifted value is at least 2^WIDTH and so always
  // exceeds the divisor. The kept difference is always below the divisor,
  // so WIDTH-bit modular subtraction gives the exact new remainder.
  assign rem_low = {rem_in[WIDTH-2:0], quo_in[WIDTH-1]};
  assign ge      = rem_in[WIDTH-1] | (rem_low >= dvs);
  assign rem_out = ge ? (rem_low - dvs) : rem_low;
  assign quo_out = {quo_in[WIDTH-2:0], ge};

endmodule

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl
// Multi-cycle DIV/DIVU sequencer for the execute stage. Holds the pipeline
// stall while a divide is in flight and returns remainder/quotient as a
// single HI/LO write pulse.
// Build option: HILO_DIV_ZERO_FAST_EN -- when defined, a zero divisor skips
// the iteration phase and produces HI=dividend, LO=all ones one cycle later.
//
// State table:
//   state   | meaning
//   ST_IDLE | waiting for start; latches operand magnitudes and result signs
//   ST_CALC | one restoring step per cycle, WIDTH cycles total, busy high
//   ST_DONE | result cycle: hi/lo loaded, whilo_out high, stall released

module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             stall_req,
  output logic             busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             whilo_out
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             quo_neg_q;
  logic             rem_neg_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] fin_rem;
  logic [WIDTH-1:0] fin_quo;

`ifdef HILO_DIV_ZERO_FAST_EN
  logic dvs_zero;
  assign dvs_zero = (divisor == '0);
`endif

  // Operand signs only matter for DIV; DIVU treats both as magnitudes.
  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor  : divisor;

  // Sign correction is applied to the final iteration's output directly so
  // the result is registered on the same edge that enters ST_DONE.
  assign fin_quo = quo_neg_q ? -step_quo : step_quo;
  assign fin_rem = rem_neg_q ? -step_rem : step_rem;

  // Stall must rise in the same cycle execute presents the divide.
  assign stall_req = ~cancel & (((state == ST_IDLE) & start) | (state == ST_CALC));

  hilo_div_ctrl_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Divide sequencer with registered busy/result/write-pulse outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      busy      <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      whilo_out <= 1'b0;
    end else if (cancel) begin
      // Flush wins everywhere; results already in hi/lo are left alone.
      state     <= ST_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      whilo_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          whilo_out <= 1'b0;
          if (start) begin
`ifdef HILO_DIV_ZERO_FAST_EN
            if (dvs_zero) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              hi_out    <= dividend;
              lo_out    <= '1;
              whilo_out <= 1'b1;
            end else
`endif
            begin
              state     <= ST_CALC;
              busy      <= 1'b1;
              cnt       <= '0;
              rem_q     <= '0;
              quo_q     <= dvd_mag;
              dvs_q     <= dvs_mag;
              quo_neg_q <= dvd_neg ^ dvs_neg;
              rem_neg_q <= dvd_neg;
            end
          end
        end
        ST_CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          if (cnt == CNT_LAST) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            hi_out    <= fin_rem;
            lo_out    <= fin_quo;
            whilo_out <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // start is ignored here; a following divide is taken next cycle.
          state     <= ST_IDLE;
          cnt       <= '0;
          whilo_out <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          whilo_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl
// Randomised and directed stimulus for hilo_div_ctrl, checked every cycle
// against an arithmetic reference model of the divide and its latency.
// Honors HILO_DIV_ZERO_FAST_EN the same way the design does.

module tb_hilo_div_ctrl;

  localparam int W = 32;
`ifdef HILO_DIV_ZERO_FAST_EN
  localparam bit ZFAST = 1'b1;
`else
  localparam bit ZFAST = 1'b0;
`endif

  logic         clk;
  logic         rstn;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         cancel;
  logic         stall_req;
  logic         busy;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
  logic         whilo_out;

  hilo_div_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .cancel    (cancel),
    .stall_req (stall_req),
    .busy      (busy),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .whilo_out (whilo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {hi,lo} from plain integer division and MIPS sign rules.
  function automatic logic [2*W-1:0] model_res(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ma, mb, qm, rm, q, r;
    if (ZFAST && b == 0) return {a, {W{1'b1}}};
    ma = (sg && a[W-1]) ? (~a + 1) : a;
    mb = (sg && b[W-1]) ? (~b + 1) : b;
    if (mb == 0) begin
      qm = {W{1'b1}};
      rm = ma;
    end else begin
      qm = ma / mb;
      rm = ma % mb;
    end
    q = (sg && (a[W-1] ^ b[W-1])) ? (~qm + 1) : qm;
    r = (sg && a[W-1]) ? (~rm + 1) : rm;
    return {r, q};
  endfunction

  // Cycles from start acceptance to the result cycle.
  function automatic int lat_of(input logic [W-1:0] b);
    return (ZFAST && b == 0) ? 1 : W + 1;
  endfunction

  // Model: cycles left until the result, result-cycle flag, expected outputs.
  int             m_left;
  bit             m_done;
  bit             m_whilo;
  logic [W-1:0]   m_hi, m_lo;
  logic [2*W-1:0] m_pend;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_whilo <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
      m_pend  <= '0;
    end else if (cancel) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_whilo <= 1'b0;
    end else if (m_done) begin
      m_done  <= 1'b0;
      m_whilo <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done        <= 1'b1;
        m_whilo       <= 1'b1;
        {m_hi, m_lo}  <= m_pend;
      end
    end else if (start) begin
      if (lat_of(divisor) == 1) begin
        m_done       <= 1'b1;
        m_whilo      <= 1'b1;
        {m_hi, m_lo} <= model_res(signed_op, dividend, divisor);
      end else begin
        m_left <= W;
        m_pend <= model_res(signed_op, dividend, divisor);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rstn && chk_en) begin
      chk("stall_req", W'(stall_req),
          W'(!cancel && ((m_left == 0 && !m_done && start) || m_left > 0)));
      chk("busy", W'(busy), W'(m_left > 0));
      chk("whilo_out", W'(whilo_out), W'(m_whilo));
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Directed divide with literal expectations; returns in the result cycle
  // when keep is set (start left high), otherwise one cycle later in IDLE.
  task automatic run_div(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input bit keep, input string nm);
    int lat;
    int nst;
    lat = lat_of(b);
    nst = 0;
    signed_op = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    for (int i = 0; i < lat; i++) begin
      #1;
      if (stall_req) nst++;
      cyc();
    end
    chk({nm, " stall cycles"}, W'(nst), W'(lat));
    chk({nm, " whilo"}, W'(whilo_out), W'(1));
    chk({nm, " hi"}, hi_out, ehi);
    chk({nm, " lo"}, lo_out, elo);
    chk({nm, " model hi"}, m_hi, ehi);
    chk({nm, " model lo"}, m_lo, elo);
    if (!keep) begin
      start = 1'b0;
      cyc();
      chk({nm, " whilo width"}, W'(whilo_out), W'(0));
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nw;
    rstn      = 1'b0;
    start     = 1'b0;
    cancel    = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    chk("reset busy", W'(busy), W'(0));
    chk("reset whilo", W'(whilo_out), W'(0));
    chk("reset stall", W'(stall_req), W'(0));
    chk("reset hi", hi_out, '0);
    chk("reset lo", lo_out, '0);
    cyc();
    cyc();
    rstn   = 1'b1;
    chk_en = 1'b1;
    cyc();

    run_div(1'b0, 100, 7, 2, 14, 1'b0, "divu 100/7");
    run_div(1'b1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div -7/2");
    run_div(1'b1, 7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 1'b0, "div 7/-2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1'b0, "div overflow");
    run_div(1'b0, 32'h1234, 0, 32'h1234, 32'hFFFF_FFFF, 1'b0, "divu by zero");

    // Back-to-back: start stays high through the result cycle.
    run_div(1'b0, 9, 2, 1, 4, 1'b1, "b2b first");
    divisor = 4;
    cyc();
    run_div(1'b0, 9, 4, 1, 2, 1'b0, "b2b second");

    // Cancel mid-CALC: no pulse, HI/LO keep the previous result.
    signed_op = 1'b0;
    dividend  = 50;
    divisor   = 3;
    start     = 1'b1;
    repeat (10) cyc();
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    start  = 1'b0;
    #1;
    chk("cancel busy", W'(busy), W'(0));
    chk("cancel whilo", W'(whilo_out), W'(0));
    chk("cancel hi held", hi_out, 1);
    chk("cancel lo held", lo_out, 2);
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      if (whilo_out) nw++;
      cyc();
    end
    chk("cancel no pulse", W'(nw), W'(0));
    run_div(1'b0, 20, 4, 0, 5, 1'b0, "divu 20/4");

    // Asynchronous reset in the middle of CALC.
    signed_op = 1'b0;
    dividend  = 1000;
    divisor   = 3;
    start     = 1'b1;
    repeat (6) cyc();
    start = 1'b0;
    rstn  = 1'b0;
    #1;
    chk("midreset busy", W'(busy), W'(0));
    chk("midreset whilo", W'(whilo_out), W'(0));
    chk("midreset stall", W'(stall_req), W'(0));
    chk("midreset hi", hi_out, '0);
    chk("midreset lo", lo_out, '0);
    cyc();
    rstn = 1'b1;
    cyc();

    // Randomised divides with occasional cancels and idle gaps.
    for (int n = 0; n < 150; n++) begin
      int lat;
      int cat;
      signed_op = 1'($urandom % 2);
      dividend  = pick();
      divisor   = pick();
      lat       = lat_of(divisor);
      cat       = ($urandom % 6 == 0) ? int'($urandom_range(0, lat - 1)) : -1;
      start     = 1'b1;
      for (int i = 0; i < lat; i++) begin
        if (i == cat) begin
          cancel = 1'b1;
          cyc();
          cancel = 1'b0;
          start  = 1'b0;
          break;
        end
        cyc();
      end
      if (cat < 0) begin
        start = 1'b0;
        cyc();
      end
      repeat ($urandom % 3) cyc();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
